key_valid_ctrl: RTL and testbench
=================================

// Module: key_valid_ctrl
// PURPOSE
//   Upstream control stage for the LED flasher. Synchronises and debounces one
//   raw push-button (active-low) and toggles the flasher's valid/enable on each
//   confirmed press. Also exports a one-cycle press strobe and the debounced key
//   level. The valid output connects directly to the flasher's valid input.
// PARAMETERS
//   DEBOUNCE_CNT  20'd999_999  stable-level hold, in clocks, minus 1 (20 ms @ 50 MHz)
//   AUTO_OFF_CNT  28'd249_999_999  valid-on timeout, in clocks, minus 1 (5 s); used only with KEY_AUTO_OFF_EN
// PORTS
//   sys_clk      in   1  system clock, 50 MHz; the only clock
//   rst          in   1  one clock; reset is asynchronous and active-high
//   key_in       in   1  raw button, asynchronous, 0 = pressed
//   valid        out  1  flasher enable; toggles on each confirmed press
//   press_pulse  out  1  one-cycle strobe per confirmed press
//   key_level    out  1  debounced key level, 0 = pressed
// BEHAVIOUR
//   Reset: both sync FFs = 1, FSM = IDLE, cnt = 0, valid = 0, press_pulse = 0,
//     key_level = 1, auto-off timer = 0. A key held through reset needs a full debounce.
//   Sync: 2-FF synchroniser on key_in gives key_s. Nothing else samples key_in.
//   FSM (registered):
//     IDLE       key_s == 0 -> PRESS_DB, cnt <= 0.
//     PRESS_DB   key_s == 1 -> IDLE (bounce rejected, no outputs change).
//                key_s == 0 and cnt <  DEBOUNCE_CNT -> cnt++.
//                key_s == 0 and cnt == DEBOUNCE_CNT -> HELD, press_pulse <= 1,
//                  valid <= ~valid, key_level <= 0.
//     HELD       key_s == 1 -> RELEASE_DB, cnt <= 0.
//     RELEASE_DB key_s == 0 -> HELD (bounce, no output change).
//                key_s == 1 and cnt == DEBOUNCE_CNT -> IDLE, key_level <= 1.
//   Latency: first sampling edge with key_in = 0, stable, to press_pulse high is
//     DEBOUNCE_CNT+3 clocks. Release has no strobe.
//   press_pulse is high for exactly 1 cycle. Holding the key never repeats it.
//   Counter width is $clog2(DEBOUNCE_CNT+1). The counter never wraps, because
//     every state that reaches DEBOUNCE_CNT leaves that state.
//   Reset mid-debounce: the debounce is abandoned. No press_pulse, valid = 0.
// CONFIGURATION
//   KEY_AUTO_OFF_EN defined:
//     - Timer runs while valid = 1 and is held at 0 while valid = 0.
//     - Timer == AUTO_OFF_CNT -> valid <= 0, timer <= 0, no press_pulse.
//     - A press on the same cycle as the timeout wins: valid <= ~valid, i.e. 0, and timer <= 0.
//     - Any press clears the timer.
//   KEY_AUTO_OFF_EN undefined: no timer logic. valid changes only on presses.
// STRUCTURE
//   Package key_ctrl_pkg:
//     - typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} key_state_t
//     - default DEBOUNCE_CNT and AUTO_OFF_CNT constants
//   Sub-module key_sync: 2-FF synchroniser with parameterised reset value (1 here).
//   All other logic stays in key_valid_ctrl.
// TESTING (bench uses DEBOUNCE_CNT=4, AUTO_OFF_CNT=20)
//   1 Clean press: key_in 1->0 held 20 clks -> press_pulse high 1 cycle,
//     7 clks after first low sample; valid 0->1; key_level 0.
//   2 Bounce: key_in 0 for 3 clks, then 1, repeated 5 times -> no press_pulse;
//     valid stays 0; key_level stays 1.
//   3 Release + second press: release held 10 clks, then press 10 clks ->
//     key_level returns to 1 after release debounce; second press_pulse; valid 1->0.
//   4 Reset in PRESS_DB: assert rst 2 clks at cnt=2 with key still low -> all
//     outputs at reset values immediately; after rst drop, press_pulse 7 clks later.
//   5 KEY_AUTO_OFF_EN: press, then idle -> valid clears 21 clks after going
//     high. Press on the timeout cycle -> valid = 0, timer = 0.
//   6 Held key: key_in low 200 clks -> exactly one press_pulse; valid toggles once.

Source files
------------

// File: rtl/key_ctrl_pkg.sv
// Shared types and default timing constants for the key/valid control stage.
package key_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} key_state_t;

  // 20 ms debounce and 5 s auto-off at 50 MHz, both expressed as count-1.
  localparam int unsigned DEBOUNCE_CNT_DEF = 999_999;
  localparam int unsigned AUTO_OFF_CNT_DEF = 249_999_999;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for one asynchronous input, with a selectable reset level.
module key_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/key_valid_ctrl.sv
// Debounces an active-low push-button and toggles the flasher valid on each press.
// Optional valid auto-off timer is enabled by defining KEY_AUTO_OFF_EN.
module key_valid_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
`ifdef KEY_AUTO_OFF_EN
  , parameter int unsigned AUTO_OFF_CNT = AUTO_OFF_CNT_DEF
`endif
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic key_in,
  output logic valid,
  output logic press_pulse,
  output logic key_level
);

  localparam int unsigned CNT_W = (DEBOUNCE_CNT > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT);

  logic             w_key_s;
  key_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_pulse, w_pulse_nxt;
  logic             r_level, w_level_nxt;
  logic             w_press;

  key_sync #(.RST_VAL(1'b1)) u_key_sync (
    .i_clk (sys_clk),
    .i_rst (rst),
    .i_d   (key_in),
    .o_q   (w_key_s)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_pulse <= 1'b0;
      r_level <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_pulse <= w_pulse_nxt;
      r_level <= w_level_nxt;
    end
  end

  // Debounce FSM: the counter only advances while the level stays put.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse_nxt = 1'b0;
    w_level_nxt = r_level;
    w_press     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_key_s) begin
          w_state_nxt = PRESS_DB;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_DB: begin
        if (w_key_s) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = HELD;
          w_pulse_nxt = 1'b1;
          w_level_nxt = 1'b0;
          w_press     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (w_key_s) begin
          w_state_nxt = RELEASE_DB;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_DB: begin
        if (!w_key_s) begin
          w_state_nxt = HELD;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = IDLE;
          w_level_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
    endcase
  end

`ifdef KEY_AUTO_OFF_EN
  localparam int unsigned TMR_W = (AUTO_OFF_CNT > 0) ? $clog2(AUTO_OFF_CNT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(AUTO_OFF_CNT);

  logic [TMR_W-1:0] r_timer, w_timer_nxt;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) r_timer <= '0;
    else     r_timer <= w_timer_nxt;
  end

  // A press on the timeout cycle takes priority over the timeout.
  always_comb begin
    w_valid_nxt = r_valid;
    w_timer_nxt = r_timer;
    if (w_press) begin
      w_valid_nxt = ~r_valid;
      w_timer_nxt = '0;
    end else if (!r_valid) begin
      w_timer_nxt = '0;
    end else if (r_timer == TMR_MAX) begin
      w_valid_nxt = 1'b0;
      w_timer_nxt = '0;
    end else begin
      w_timer_nxt = r_timer + TMR_W'(1);
    end
  end
`else
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_press) w_valid_nxt = ~r_valid;
  end
`endif

  assign valid       = r_valid;
  assign press_pulse = r_pulse;
  assign key_level   = r_level;

endmodule

// File: tb/tb_key_valid_ctrl.sv
// Directed bench for key_valid_ctrl: scoreboard of expected strobe cycles plus a valid model.
module tb_key_valid_ctrl;

  localparam int unsigned DB  = 4;
  localparam int unsigned AO  = 20;
  localparam int          LAT = DB + 4;

  logic sys_clk = 1'b0;
  logic rst;
  logic key_in;
  logic valid;
  logic press_pulse;
  logic key_level;

  always #5 sys_clk = ~sys_clk;

  key_valid_ctrl #(
    .DEBOUNCE_CNT (DB)
`ifdef KEY_AUTO_OFF_EN
    , .AUTO_OFF_CNT (AO)
`endif
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .key_in      (key_in),
    .valid       (valid),
    .press_pulse (press_pulse),
    .key_level   (key_level)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   exp_q[$];
  logic m_valid = 1'b0;
  int   m_timer = 0;
  int   p_mark;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_press();
    exp_q.push_back(cyc + LAT);
  endtask

  // One clock: advance, score any strobe, update the valid model, compare valid.
  task automatic tick();
    logic exp_press;
    @(posedge sys_clk);
    #1;
    cyc++;
    exp_press = (exp_q.size() > 0) && (exp_q[0] == cyc);
    if (exp_press || (press_pulse !== 1'b0)) begin
      check("press_pulse", press_pulse, exp_press);
      if (exp_press) void'(exp_q.pop_front());
    end
    if (rst) begin
      m_valid = 1'b0;
      m_timer = 0;
    end else if (exp_press) begin
      m_valid = ~m_valid;
      m_timer = 0;
    end
`ifdef KEY_AUTO_OFF_EN
    else if (!m_valid) m_timer = 0;
    else if (m_timer == AO) begin
      m_valid = 1'b0;
      m_timer = 0;
    end else m_timer++;
`endif
    check("valid", valid, m_valid);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst    = 1'b1;
    key_in = 1'b1;
    ticks(3);
    check("rst_valid", valid, 1'b0);
    check("rst_pulse", press_pulse, 1'b0);
    check("rst_level", key_level, 1'b1);
    rst = 1'b0;
    ticks(3);

    // Bounce: short lows never complete a debounce
    for (int i = 0; i < 5; i++) begin
      key_in = 1'b0;
      ticks(3);
      key_in = 1'b1;
      ticks(3);
    end
    ticks(10);
    check("bounce_level", key_level, 1'b1);
    check("bounce_valid", valid, 1'b0);

    // Clean press
    key_in = 1'b0;
    expect_press();
    ticks(20);
    check("press1_level", key_level, 1'b0);
    check("press1_valid", valid, 1'b1);

    // Release then second press
    key_in = 1'b1;
    ticks(10);
    check("release1_level", key_level, 1'b1);
    key_in = 1'b0;
    expect_press();
    ticks(10);
    check("press2_level", key_level, 1'b0);
    key_in = 1'b1;
    ticks(10);
    check("release2_level", key_level, 1'b1);

    // Long hold gives a single strobe
    key_in = 1'b0;
    expect_press();
    ticks(200);
    check("held_level", key_level, 1'b0);
    key_in = 1'b1;
    ticks(10);
    check("held_rel_level", key_level, 1'b1);

    // Reset while in PRESS_DB with cnt = 2
    key_in = 1'b0;
    ticks(5);
    rst = 1'b1;
    #1;
    m_valid = 1'b0;
    m_timer = 0;
    check("midrst_valid", valid, 1'b0);
    check("midrst_pulse", press_pulse, 1'b0);
    check("midrst_level", key_level, 1'b1);
    ticks(2);
    rst = 1'b0;
    expect_press();
    ticks(15);
    check("postrst_level", key_level, 1'b0);
    key_in = 1'b1;
    ticks(10);

`ifdef KEY_AUTO_OFF_EN
    ticks(30);
    check("ao_start_valid", valid, 1'b0);
    key_in = 1'b0;
    expect_press();
    ticks(LAT);
    check("ao_on_valid", valid, 1'b1);
    key_in = 1'b1;
    ticks(20);
    check("ao_before_to", valid, 1'b1);
    ticks(1);
    check("ao_after_to", valid, 1'b0);

    // Press lands exactly on the timeout cycle
    key_in = 1'b0;
    expect_press();
    p_mark = cyc + LAT;
    ticks(LAT);
    check("ao2_on_valid", valid, 1'b1);
    key_in = 1'b1;
    ticks(13);
    key_in = 1'b0;
    expect_press();
    check("ao2_aligned", logic'(exp_q[0] == p_mark + 21), 1'b1);
    ticks(10);
    key_in = 1'b1;
    ticks(40);
    check("ao2_final_valid", valid, 1'b0);
`endif

    check("sb_empty", logic'(exp_q.size() == 0), 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
